// File: rtl/mult_wb_sched_if.sv
// Bus between the multiply writeback scheduler and its neighbours: issue handshake,
// per-slot hazard vectors, the shared regfile write port and performance counters.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 4
`endif

interface mult_wb_sched_if #(
    parameter int STAGES = `MULT_PPL_STAGE
);
    logic                    issue_valid_i;
    logic [4:0]              issue_rd_i;
    logic                    issue_ready_o;
    logic                    mult_adv_o;
    logic [31:0]             mult_result_i;
    logic [STAGES-1:0][4:0]  rd_addrs_o;
    logic [STAGES-1:0]       mult_uses_o;
    logic                    pipe_we_i;
    logic [4:0]              pipe_waddr_i;
    logic [31:0]             pipe_wdata_i;
    logic                    pipe_stall_o;
    logic                    rf_we_o;
    logic [4:0]              rf_waddr_o;
    logic [31:0]             rf_wdata_o;
    logic [31:0]             perf_issue_o;
    logic [31:0]             perf_wait_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, mult_result_i,
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        output issue_ready_o, mult_adv_o, rd_addrs_o, mult_uses_o,
        output pipe_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output perf_issue_o, perf_wait_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, mult_result_i,
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        input  issue_ready_o, mult_adv_o, rd_addrs_o, mult_uses_o,
        input  pipe_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  perf_issue_o, perf_wait_o
    );
endinterface

// File: rtl/mult_wb_sched.sv
// Multiply issue/writeback scheduler: per-stage rd tracking, regfile write-port arbitration
// with starvation bound. Define MULT_PERF_EN to build the issue/wait performance counters.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 4
`endif

module mult_wb_sched #(
    parameter int STAGES       = `MULT_PPL_STAGE,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    mult_wb_sched_if.slave    bus
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [STAGES-1:0]       slot_v_reg;
    logic [STAGES-1:0]       slot_v_next;
    logic [STAGES-1:0][4:0]  slot_rd_reg;
    logic [STAGES-1:0][4:0]  slot_rd_next;
    logic [CW-1:0]           starve_cnt_reg;
    logic [CW-1:0]           starve_cnt_next;

    logic pipe_req;
    logic last;
    logic starved;
    logic mult_win;
    logic adv;
    logic issue_take;

    assign pipe_req   = bus.pipe_we_i && (bus.pipe_waddr_i != 5'd0);
    assign last       = slot_v_reg[STAGES-1];
    assign starved    = (starve_cnt_reg == CW'(STARVE_LIMIT));
    assign mult_win   = last && (!pipe_req || starved);
    assign adv        = !last || mult_win;
    // rd==0 is acknowledged but never tracked, so it can neither stall nor write
    assign issue_take = bus.issue_valid_i && (bus.issue_rd_i != 5'd0);

    assign slot_v_next[0]  = issue_take;
    assign slot_rd_next[0] = issue_take ? bus.issue_rd_i : 5'd0;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
            assign slot_v_next[gi]  = slot_v_reg[gi-1];
            assign slot_rd_next[gi] = slot_rd_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v_reg  <= '0;
            slot_rd_reg <= '0;
        end else if (adv) begin
            slot_v_reg  <= slot_v_next;
            slot_rd_reg <= slot_rd_next;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (mult_win)
            starve_cnt_next = '0;
        else if (last && !starved)
            starve_cnt_next = starve_cnt_reg + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt_reg <= '0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end

    always_comb begin
        bus.rf_we_o    = 1'b0;
        bus.rf_waddr_o = 5'd0;
        bus.rf_wdata_o = 32'd0;
        if (mult_win) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_waddr_o = slot_rd_reg[STAGES-1];
            bus.rf_wdata_o = bus.mult_result_i;
        end else if (pipe_req) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_waddr_o = bus.pipe_waddr_i;
            bus.rf_wdata_o = bus.pipe_wdata_i;
        end
    end

    assign bus.issue_ready_o = adv;
    assign bus.mult_adv_o    = adv;
    assign bus.pipe_stall_o  = mult_win && pipe_req;
    assign bus.mult_uses_o   = slot_v_reg;
    assign bus.rd_addrs_o    = slot_rd_reg;

`ifdef MULT_PERF_EN
    logic [31:0] perf_issue_reg;
    logic [31:0] perf_wait_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_reg <= 32'd0;
            perf_wait_reg  <= 32'd0;
        end else begin
            if (adv && issue_take)
                perf_issue_reg <= perf_issue_reg + 32'd1;
            if (!adv)
                perf_wait_reg <= perf_wait_reg + 32'd1;
        end
    end

    assign bus.perf_issue_o = perf_issue_reg;
    assign bus.perf_wait_o  = perf_wait_reg;
`else
    assign bus.perf_issue_o = 32'd0;
    assign bus.perf_wait_o  = 32'd0;
`endif

endmodule
